// File: rtl/ram_btn_scanner_pkg.sv
// Shared types and helpers for the button-driven RAM viewer: FSM states,
// address-step commands, button indices and command priority.
package ram_scan_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    CAPTURE
  } state_t;

  typedef enum logic [1:0] {
    NONE,
    INC,
    DEC,
    HOME
  } cmd_t;

  localparam int NUM_BTN  = 3;
  localparam int BTN_INC  = 0;
  localparam int BTN_DEC  = 1;
  localparam int BTN_HOME = 2;

  // Larger value wins when two commands compete.
  function automatic logic [1:0] cmd_prio(input cmd_t c);
    case (c)
      HOME:    cmd_prio = 2'd3;
      INC:     cmd_prio = 2'd2;
      DEC:     cmd_prio = 2'd1;
      default: cmd_prio = 2'd0;
    endcase
  endfunction

  // Collapse simultaneous press events into one command: HOME > INC > DEC.
  function automatic cmd_t pick_cmd(input logic [NUM_BTN-1:0] ev);
    if (ev[BTN_HOME])     pick_cmd = HOME;
    else if (ev[BTN_INC]) pick_cmd = INC;
    else if (ev[BTN_DEC]) pick_cmd = DEC;
    else                  pick_cmd = NONE;
  endfunction

endpackage

// File: rtl/ram_btn_scanner_debounce.sv
// Per-button synchroniser and debouncer: emits the accepted level and a
// one-cycle pulse on each debounced released->pressed edge.
module btn_debounce #(
  parameter int DEBOUNCE_CYC = 50000,
  parameter bit ACTIVE_LOW   = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic level,
  output logic press
);

  localparam int            CW       = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYC - 1);
  localparam logic          IDLE_RAW = ACTIVE_LOW;

  logic          sync1;
  logic          sync2;
  logic          sample;
  logic [CW-1:0] cnt;

  // Normalised so that 1 always means "pressed".
  assign sample = sync2 ^ ACTIVE_LOW;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1 <= IDLE_RAW;
      sync2 <= IDLE_RAW;
      level <= 1'b0;
      press <= 1'b0;
      cnt   <= '0;
    end else begin
      // NOTE: non-blocking assignments keep every flop sampling pre-edge values,
      // which is what makes sync1 -> sync2 a real two-stage synchroniser.
      sync1 <= raw;
      sync2 <= sync1;
      press <= 1'b0;
      if (sample == level) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        level <= sample;
        press <= sample;
        cnt   <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/ram_btn_scanner.sv
// Button-driven viewer for a synchronous data RAM: debounced INC/DEC/HOME
// presses step a wrapping pointer and trigger single reads whose result is
// shown on q with a valid strobe. Optional macro RAM_SCAN_AUTO_EN adds a
// periodic auto-increment while no button is held.
module ram_btn_scanner
  import ram_scan_pkg::*;
#(
  parameter int DATA_W         = 32,
  parameter int ADDR_W         = 16,
  parameter int DEPTH          = 65536,
  parameter int STEP           = 1,
  parameter int READ_LAT       = 2,
  parameter int DEBOUNCE_CYC   = 50000,
  parameter bit BTN_ACTIVE_LOW = 1'b1
`ifdef RAM_SCAN_AUTO_EN
  ,
  parameter int SCAN_PERIOD    = 25_000_000
`endif
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [2:0]        btn,
  input  logic [DATA_W-1:0] ram_q,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_rden,
  output logic [DATA_W-1:0] q,
  output logic [ADDR_W-1:0] address,
  output logic              valid,
  output logic              busy
);

  localparam logic [ADDR_W:0] DEPTH_X  = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W:0] STEP_X   = (ADDR_W + 1)'(STEP);
  localparam logic [2:0]      LAT_INIT = 3'(READ_LAT - 1);

  logic [NUM_BTN-1:0] level;
  logic [NUM_BTN-1:0] press;
  cmd_t               btn_cmd;
  cmd_t               new_cmd;
  cmd_t               pending;
  cmd_t               merged;
  state_t             state;
  state_t             nstate;
  logic               boot;
  logic               start_read;
  logic [2:0]         lat_cnt;
  logic [ADDR_W-1:0]  next_address;

  for (genvar i = 0; i < NUM_BTN; i++) begin : g_btn
    btn_debounce #(
      .DEBOUNCE_CYC (DEBOUNCE_CYC),
      .ACTIVE_LOW   (BTN_ACTIVE_LOW)
    ) u_deb (
      .clk   (clk),
      .rst   (rst),
      .raw   (btn[i]),
      .level (level[i]),
      .press (press[i])
    );
  end

  assign btn_cmd = pick_cmd(press);

`ifdef RAM_SCAN_AUTO_EN
  localparam logic [31:0] SCAN_LAST = 32'(SCAN_PERIOD - 1);

  logic [31:0] scan_cnt;
  logic        scan_tick;

  assign scan_tick = (state == IDLE) && !(|level) && !(|press) && (scan_cnt == SCAN_LAST);
  assign new_cmd   = (btn_cmd == NONE && scan_tick) ? INC : btn_cmd;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      scan_cnt <= '0;
    end else if (|press) begin
      scan_cnt <= '0;
    end else if (state == IDLE && !(|level)) begin
      scan_cnt <= scan_tick ? '0 : scan_cnt + 32'd1;
    end
  end
`else
  logic unused_level;

  assign new_cmd      = btn_cmd;
  assign unused_level = ^level;
`endif

  // Wrap-around stepping done one bit wider so DEPTH == 2**ADDR_W still fits.
  function automatic logic [ADDR_W-1:0] step_addr(input logic [ADDR_W-1:0] a, input cmd_t c);
    logic [ADDR_W:0] ext;
    logic [ADDR_W:0] res;
    ext = {1'b0, a};
    res = ext;
    case (c)
      HOME: res = '0;
      INC: begin
        res = ext + STEP_X;
        if (res >= DEPTH_X) res = res - DEPTH_X;
      end
      DEC: res = (ext < STEP_X) ? ext + DEPTH_X - STEP_X : ext - STEP_X;
      default: res = ext;
    endcase
    return res[ADDR_W-1:0];
  endfunction

  // A fresh event only displaces a buffered one of strictly lower priority.
  assign merged       = (cmd_prio(new_cmd) >= cmd_prio(pending)) ? new_cmd : pending;
  assign next_address = step_addr(address, merged);
  assign start_read   = (state == IDLE) && (boot || merged != NONE);

  always_comb begin
    // NOTE: nstate gets its default before the case so no path leaves it
    // unassigned; that is what keeps this block free of inferred latches.
    nstate = state;
    case (state)
      IDLE:    if (start_read) nstate = ISSUE;
      ISSUE:   nstate = (READ_LAT == 1) ? CAPTURE : WAIT;
      WAIT:    if (lat_cnt == 3'd1) nstate = CAPTURE;
      CAPTURE: nstate = IDLE;
      default: nstate = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      boot     <= 1'b1;
      pending  <= NONE;
      address  <= '0;
      ram_addr <= '0;
      q        <= '0;
      valid    <= 1'b0;
      lat_cnt  <= '0;
    end else begin
      state <= nstate;
      boot  <= 1'b0;
      valid <= (state == CAPTURE);
      if (state == CAPTURE) q <= ram_q;

      if (state == ISSUE)     lat_cnt <= LAT_INIT;
      else if (state == WAIT) lat_cnt <= lat_cnt - 3'd1;

      if (state == IDLE) begin
        pending <= NONE;
        if (start_read) begin
          address  <= next_address;
          ram_addr <= next_address;
        end
      end else if (new_cmd != NONE && cmd_prio(new_cmd) >= cmd_prio(pending)) begin
        pending <= new_cmd;
      end
    end
  end

  assign ram_rden = (state == ISSUE);
  assign busy     = (state != IDLE);

endmodule

// File: tb/tb_ram_btn_scanner.sv
// Self-checking bench for ram_btn_scanner: directed scenarios plus random
// presses, scored against a modular-arithmetic model of the pointer.
module tb_ram_btn_scanner;

  localparam int DATA_W   = 32;
  localparam int ADDR_W   = 16;
  localparam int DEPTH    = 8;
  localparam int STEP     = 1;
  localparam int READ_LAT = 2;
  localparam int DEB      = 4;

  logic              clk;
  logic              rst;
  logic [2:0]        btn;
  logic [DATA_W-1:0] ram_q;
  logic [ADDR_W-1:0] ram_addr;
  logic              ram_rden;
  logic [DATA_W-1:0] q;
  logic [ADDR_W-1:0] address;
  logic              valid;
  logic              busy;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int nvalid   = 0;
  int last_valid_cyc = 0;
  int press_cyc = 0;
  int model_addr = 0;
  int exp_q[$];
  logic [DATA_W-1:0] rd_pipe [READ_LAT];

  ram_btn_scanner #(
    .DATA_W         (DATA_W),
    .ADDR_W         (ADDR_W),
    .DEPTH          (DEPTH),
    .STEP           (STEP),
    .READ_LAT       (READ_LAT),
    .DEBOUNCE_CYC   (DEB),
    .BTN_ACTIVE_LOW (1'b1)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .btn      (btn),
    .ram_q    (ram_q),
    .ram_addr (ram_addr),
    .ram_rden (ram_rden),
    .q        (q),
    .address  (address),
    .valid    (valid),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [DATA_W-1:0] mem_word(input int a);
    return 32'hA000_0000 + DATA_W'(a);
  endfunction

  // Synchronous RAM with READ_LAT cycles from the sampling edge to data.
  always @(posedge clk) begin
    if (ram_rden) rd_pipe[0] <= mem_word(int'(ram_addr));
    for (int i = 1; i < READ_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
  end
  assign ram_q = rd_pipe[READ_LAT-1];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst && valid) begin
      nvalid++;
      last_valid_cyc = cyc;
      if (exp_q.size() == 0) begin
        check("unexpected_valid", 64'(address), 64'hFFFF_FFFF);
      end else begin
        int ea;
        ea = exp_q.pop_front();
        check("valid_addr", 64'(address), 64'(ea));
        check("valid_q", 64'(q), 64'(mem_word(ea)));
        check("busy_at_valid", 64'(busy), 64'd0);
      end
    end
  end

  // Address stepping rules written as plain modular arithmetic.
  task automatic apply_model(input logic [2:0] m);
    if (m == 3'b000) return;
    if (m[2])      model_addr = 0;
    else if (m[0]) model_addr = (model_addr + STEP) % DEPTH;
    else           model_addr = (model_addr - STEP + DEPTH) % DEPTH;
    exp_q.push_back(model_addr);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_address"}, 64'(address), 64'd0);
    check({tag, "_q"}, 64'(q), 64'd0);
    check({tag, "_valid"}, 64'(valid), 64'd0);
    check({tag, "_busy"}, 64'(busy), 64'd0);
    check({tag, "_rden"}, 64'(ram_rden), 64'd0);
    check({tag, "_ram_addr"}, 64'(ram_addr), 64'd0);
  endtask

  task automatic wait_done(input string tag, input int budget);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || busy) && n < budget) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_done"}, 64'(exp_q.size() == 0 && !busy), 64'd1);
    check({tag, "_idle_addr"}, 64'(address), 64'(model_addr));
    exp_q.delete();
  endtask

  task automatic settle();
    repeat (DEB + 4) @(negedge clk);
  endtask

  task automatic press(input logic [2:0] m, input int hold);
    btn = ~m;
    press_cyc = cyc;
    apply_model(m);
    repeat (hold) @(negedge clk);
    btn = 3'b111;
    wait_done("press", 60);
    settle();
  endtask

  task automatic press_pair(input logic [2:0] a, input logic [2:0] b);
    int nv;
    nv = nvalid;
    btn = ~a;
    apply_model(a);
    repeat (2) @(negedge clk);
    btn = ~(a | b);
    apply_model(b);
    repeat (10) @(negedge clk);
    btn = 3'b111;
    wait_done("pair", 80);
    check("pair_two_valids", 64'(nvalid - nv), 64'd2);
    settle();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int nv;
    int lat;
    int start;
    int n;
    rst = 1'b0;
    btn = 3'b111;
    repeat (3) @(negedge clk);
    check_reset_outputs("por");

    exp_q.push_back(0);
    rst = 1'b1;
    wait_done("boot", 5);
    settle();

    nv = nvalid;
    press(3'b001, 10);
    check("inc_one_valid", 64'(nvalid - nv), 64'd1);
    lat = last_valid_cyc - press_cyc;
    check("inc_latency_window",
          64'(lat >= READ_LAT + 2 + DEB && lat <= READ_LAT + 2 + DEB + 4), 64'd1);

    press(3'b100, 8);
    press(3'b010, 8);
    check("dec_wrap_addr", 64'(address), 64'd7);
    press(3'b001, 8);
    check("inc_wrap_addr", 64'(address), 64'd0);

    nv = nvalid;
    press(3'b101, 8);
    check("inc_home_one_valid", 64'(nvalid - nv), 64'd1);
    repeat (5) press(3'b001, 8);
    check("at_five", 64'(address), 64'd5);
    press(3'b111, 8);
    check("home_wins", 64'(address), 64'd0);

    nv = nvalid;
    btn = 3'b110;
    repeat (2) @(negedge clk);
    btn = 3'b111;
    repeat (20) @(negedge clk);
    check("glitch_no_valid", 64'(nvalid - nv), 64'd0);

    start = model_addr;
    press_pair(3'b001, 3'b010);
    check("inc_dec_back", 64'(address), 64'(start));

    btn = 3'b110;
    n = 0;
    while (!(busy && !ram_rden) && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("reach_wait", 64'(busy && !ram_rden), 64'd1);
    nv = nvalid;
    rst = 1'b0;
    btn = 3'b111;
    exp_q.delete();
    #1;
    check_reset_outputs("mid");
    repeat (4) @(negedge clk);
    check_reset_outputs("mid_hold");
    check("abort_no_valid", 64'(nvalid - nv), 64'd0);
    model_addr = 0;
    exp_q.push_back(0);
    rst = 1'b1;
    wait_done("reread", 6);
    settle();

    for (int it = 0; it < 30; it++) begin
      repeat ($urandom_range(0, 5)) @(negedge clk);
      if ($urandom_range(0, 2) == 0) begin
        int ia;
        int ib;
        ia = $urandom_range(0, 2);
        ib = (ia + $urandom_range(1, 2)) % 3;
        press_pair(3'(1 << ia), 3'(1 << ib));
      end else begin
        press(3'($urandom_range(1, 7)), $urandom_range(DEB + 3, 20));
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
